// File: rtl/follow_cmd_ctrl.sv
// follow_cmd_ctrl: run sequencer for the line-follower robot.
// Ports: clk, rst_n (sync, active-low); cmd/cmd_rdy/clr_cmd_rdy command
//   handshake; ID/ID_vld/clr_ID_vld barcode handshake; line_present,
//   bump_n sensors; go, buzz, lost, busy registered status outputs.
module follow_cmd_ctrl #(
    parameter int FAST_SIM   = 0,
    parameter int LOST_CYC   = 4096,
    parameter int SETTLE_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       line_present,
    input  logic       bump_n,
    output logic       go,
    output logic       buzz,
    output logic       lost,
    output logic       busy
);

    localparam int LOST_LIM   = (FAST_SIM != 0) ? 64 : LOST_CYC;
    localparam int SETTLE_LIM = (FAST_SIM != 0) ? 16 : SETTLE_CYC;
    localparam logic [11:0] LOST_END   = 12'(LOST_LIM - 1);
    localparam logic [11:0] SETTLE_END = 12'(SETTLE_LIM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        BUMP = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  dest_q;
    logic [11:0] lost_cnt_q;
    logic [11:0] settle_cnt_q;
    logic        go_q;
    logic        buzz_q;
    logic        lost_q;
    logic        busy_q;
    logic        clr_cmd_q;
    logic        clr_id_q;

    // A request is new only while our own clear pulse is not out,
    // so a held valid is never consumed twice.
    logic cmd_v;
    logic id_v;
    logic op_go;
    logic op_stop;
    logic id_hit;
    logic line_gone;

    assign cmd_v     = cmd_rdy && !clr_cmd_q;
    assign id_v      = ID_vld && !clr_id_q;
    assign op_go     = cmd_v && (cmd[7:6] == 2'b01);
    assign op_stop   = cmd_v && (cmd[7:6] == 2'b00);
    assign id_hit    = id_v && (ID[7:6] == 2'b00) && (ID[5:0] == dest_q);
    assign line_gone = !line_present && (lost_cnt_q == LOST_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dest_q       <= '0;
            lost_cnt_q   <= '0;
            settle_cnt_q <= '0;
            go_q         <= 1'b0;
            buzz_q       <= 1'b0;
            lost_q       <= 1'b0;
            busy_q       <= 1'b0;
            clr_cmd_q    <= 1'b0;
            clr_id_q     <= 1'b0;
        end else begin
            clr_cmd_q <= cmd_v;
            clr_id_q  <= id_v;
            unique case (state_q)
                IDLE: begin
                    lost_cnt_q   <= '0;
                    settle_cnt_q <= '0;
                    if (op_go) begin
                        dest_q  <= cmd[5:0];
                        lost_q  <= 1'b0;
                        go_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    settle_cnt_q <= '0;
                    if (!bump_n) begin
                        go_q       <= 1'b0;
                        buzz_q     <= 1'b1;
                        lost_cnt_q <= '0;
                        state_q    <= BUMP;
                    end else if (op_stop) begin
                        go_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        lost_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (line_gone) begin
                        go_q       <= 1'b0;
                        lost_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        lost_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else if (id_hit) begin
                        go_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        lost_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        if (op_go) begin
                            dest_q <= cmd[5:0];
                        end
                        if (line_present) begin
                            lost_cnt_q <= '0;
                        end else if (lost_cnt_q != 12'hFFF) begin
                            lost_cnt_q <= lost_cnt_q + 12'd1;
                        end
                    end
                end
                BUMP: begin
                    lost_cnt_q <= '0;
                    if (op_stop) begin
                        buzz_q       <= 1'b0;
                        busy_q       <= 1'b0;
                        settle_cnt_q <= '0;
                        state_q      <= IDLE;
                    end else begin
                        if (op_go) begin
                            dest_q <= cmd[5:0];
                        end
                        if (!bump_n) begin
                            settle_cnt_q <= '0;
                        end else if (settle_cnt_q == SETTLE_END) begin
                            buzz_q       <= 1'b0;
                            go_q         <= 1'b1;
                            settle_cnt_q <= '0;
                            state_q      <= RUN;
                        end else if (settle_cnt_q != 12'hFFF) begin
                            settle_cnt_q <= settle_cnt_q + 12'd1;
                        end
                    end
                end
                default: begin
                    go_q    <= 1'b0;
                    buzz_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign clr_cmd_rdy = clr_cmd_q;
    assign clr_ID_vld  = clr_id_q;
    assign go          = go_q;
    assign buzz        = buzz_q;
    assign lost        = lost_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_follow_cmd_ctrl.sv
// tb_follow_cmd_ctrl: directed bench for follow_cmd_ctrl with FAST_SIM=1.
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_follow_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       line_present;
    logic       bump_n;
    logic       go;
    logic       buzz;
    logic       lost;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    follow_cmd_ctrl #(
        .FAST_SIM(1),
        .LOST_CYC(4096),
        .SETTLE_CYC(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ID(ID),
        .ID_vld(ID_vld),
        .clr_ID_vld(clr_ID_vld),
        .line_present(line_present),
        .bump_n(bump_n),
        .go(go),
        .buzz(buzz),
        .lost(lost),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic send_go(input logic [7:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        cmd          = 8'h00;
        cmd_rdy      = 1'b0;
        ID           = 8'h00;
        ID_vld       = 1'b0;
        line_present = 1'b1;
        bump_n       = 1'b1;
        step();
        step();
        chk("rst_go", go, 1'b0);
        chk("rst_buzz", buzz, 1'b0);
        chk("rst_lost", lost, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_clrcmd", clr_cmd_rdy, 1'b0);
        chk("rst_clrid", clr_ID_vld, 1'b0);
        rst_n = 1'b1;
        step();

        // invalid opcode in IDLE: consumed, no run
        cmd     = 8'hC5;
        cmd_rdy = 1'b1;
        step();
        chk("inv_clr", clr_cmd_rdy, 1'b1);
        chk("inv_go", go, 1'b0);
        cmd_rdy = 1'b0;
        step();
        chk("inv_clr_end", clr_cmd_rdy, 1'b0);

        // GO dest=5, cmd_rdy held through the pulse cycle
        cmd     = 8'h45;
        cmd_rdy = 1'b1;
        step();
        chk("go_clr", clr_cmd_rdy, 1'b1);
        chk("go_go", go, 1'b1);
        chk("go_busy", busy, 1'b1);
        step();
        chk("go_nodouble", clr_cmd_rdy, 1'b0);
        cmd_rdy = 1'b0;
        step();
        chk("go_clr_idle", clr_cmd_rdy, 1'b0);

        // non-matching IDs keep running
        ID     = 8'h03;
        ID_vld = 1'b1;
        step();
        chk("id3_clr", clr_ID_vld, 1'b1);
        chk("id3_go", go, 1'b1);
        ID_vld = 1'b0;
        step();
        ID     = 8'h45;
        ID_vld = 1'b1;
        step();
        chk("id45_clr", clr_ID_vld, 1'b1);
        chk("id45_go", go, 1'b1);
        ID_vld = 1'b0;
        step();
        ID     = 8'h05;
        ID_vld = 1'b1;
        step();
        chk("id5_clr", clr_ID_vld, 1'b1);
        chk("id5_go", go, 1'b0);
        chk("id5_busy", busy, 1'b0);
        chk("id5_lost", lost, 1'b0);
        ID_vld = 1'b0;
        step();

        // line loss with a glitch after 40 cycles
        send_go(8'h47);
        line_present = 1'b0;
        repeat (40) step();
        chk("lost40_go", go, 1'b1);
        line_present = 1'b1;
        step();
        line_present = 1'b0;
        repeat (63) step();
        chk("lost63_go", go, 1'b1);
        step();
        chk("lost64_go", go, 1'b0);
        chk("lost64_lost", lost, 1'b1);
        chk("lost64_busy", busy, 1'b0);
        line_present = 1'b1;
        step();
        chk("lost_sticky", lost, 1'b1);
        send_go(8'h45);
        chk("relaunch_lost", lost, 1'b0);
        chk("relaunch_go", go, 1'b1);
        step();

        // bump, release with a toggle at 10, settle for 16
        bump_n = 1'b0;
        step();
        chk("bump_go", go, 1'b0);
        chk("bump_buzz", buzz, 1'b1);
        chk("bump_busy", busy, 1'b1);
        repeat (4) step();
        bump_n = 1'b1;
        repeat (10) step();
        bump_n = 1'b0;
        step();
        bump_n = 1'b1;
        repeat (15) step();
        chk("settle15_buzz", buzz, 1'b1);
        chk("settle15_go", go, 1'b0);
        step();
        chk("resume_buzz", buzz, 1'b0);
        chk("resume_go", go, 1'b1);
        chk("resume_busy", busy, 1'b1);
        ID     = 8'h05;
        ID_vld = 1'b1;
        step();
        chk("resume_dest", go, 1'b0);
        ID_vld = 1'b0;
        step();

        // STOP and matching ID together
        send_go(8'h45);
        step();
        cmd     = 8'h00;
        cmd_rdy = 1'b1;
        ID      = 8'h05;
        ID_vld  = 1'b1;
        step();
        chk("both_clrcmd", clr_cmd_rdy, 1'b1);
        chk("both_clrid", clr_ID_vld, 1'b1);
        chk("both_go", go, 1'b0);
        chk("both_busy", busy, 1'b0);
        cmd_rdy = 1'b0;
        ID_vld  = 1'b0;
        step();

        // bump and STOP together: bump wins, then STOP leaves BUMP
        send_go(8'h45);
        step();
        bump_n  = 1'b0;
        cmd     = 8'h00;
        cmd_rdy = 1'b1;
        step();
        chk("bs_buzz", buzz, 1'b1);
        chk("bs_busy", busy, 1'b1);
        chk("bs_clr", clr_cmd_rdy, 1'b1);
        cmd_rdy = 1'b0;
        bump_n  = 1'b1;
        step();
        cmd_rdy = 1'b1;
        step();
        chk("bstop_buzz", buzz, 1'b0);
        chk("bstop_busy", busy, 1'b0);
        chk("bstop_go", go, 1'b0);
        cmd_rdy = 1'b0;
        step();

        // reset mid-run with a pending command
        send_go(8'h45);
        step();
        chk("pre_rst_go", go, 1'b1);
        rst_n   = 1'b0;
        cmd     = 8'h45;
        cmd_rdy = 1'b1;
        step();
        chk("mrst_go", go, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_clr", clr_cmd_rdy, 1'b0);
        chk("mrst_buzz", buzz, 1'b0);
        rst_n = 1'b1;
        step();
        chk("post_rst_clr", clr_cmd_rdy, 1'b1);
        chk("post_rst_go", go, 1'b1);
        cmd_rdy = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
